// File: rtl/rtc_calendar_if.sv
// Purpose: control, load, alarm and time/date signals of the real-time calendar.
// Latency: none; a pure bundle of wires with master (host) and slave (calendar) views.
// Backpressure: none; every field is a level or a one-cycle pulse, so nothing stalls.
interface rtc_calendar_if #(
    parameter int YEAR_W = 7
);
    logic              en;
    logic              load;
    logic [5:0]        load_sec;
    logic [5:0]        load_min;
    logic [4:0]        load_hour;
    logic [4:0]        load_day;
    logic [3:0]        load_month;
    logic [YEAR_W-1:0] load_year;
    logic              alarm_en;
    logic [4:0]        alarm_hour;
    logic [5:0]        alarm_min;
    logic [5:0]        seconds;
    logic [5:0]        minutes;
    logic [4:0]        hours;
    logic [4:0]        days;
    logic [3:0]        months;
    logic [YEAR_W-1:0] years;
    logic              sec_tick;
    logic              min_pulse;
    logic              alarm;
    logic              load_err;

    modport master (
        output en, load, load_sec, load_min, load_hour, load_day, load_month, load_year,
        output alarm_en, alarm_hour, alarm_min,
        input  seconds, minutes, hours, days, months, years,
        input  sec_tick, min_pulse, alarm, load_err
    );

    modport slave (
        input  en, load, load_sec, load_min, load_hour, load_day, load_month, load_year,
        input  alarm_en, alarm_hour, alarm_min,
        output seconds, minutes, hours, days, months, years,
        output sec_tick, min_pulse, alarm, load_err
    );
endinterface

// File: rtl/rtc_calendar.sv
// Purpose: seconds-to-years calendar driven by a clk prescaler, with load and minute alarm.
// Latency: a tick or load at cycle N shows on every registered output at cycle N+1.
// Backpressure: none; en freezes counting, a load always wins over a same-cycle tick.
module rtc_calendar #(
    parameter int CLK_HZ     = 50,
    parameter int MONTH_MODE = 1,
    parameter int YEAR_W     = 7
) (
    input  logic          clk,
    input  logic          reset,
    rtc_calendar_if.slave bus
);
    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

    logic [PW-1:0]     presc_q;
    logic [5:0]        sec_q, min_q;
    logic [4:0]        hour_q, day_q;
    logic [3:0]        mon_q;
    logic [YEAR_W-1:0] year_q;
    logic              sec_tick_q, min_pulse_q, alarm_q, load_err_q;

    // Days in month m of year y; invalid months fall to 31 but are never accepted by a load.
    function automatic logic [4:0] month_len(input logic [3:0] m, input logic [YEAR_W-1:0] y);
        if (MONTH_MODE == 0) return 5'd30;
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return (y[1:0] == 2'b00) ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic tick;
    assign tick = bus.en && (presc_q == PW'(CLK_HZ - 1));

    // Whole carry chain is combinational so a single tick can roll 23:59:59 31/12/99 to 00:00:00 1/1/0.
    logic sec_wrap, min_wrap, hour_wrap, day_wrap, mon_wrap;
    logic c_min, c_hour, c_day, c_mon, c_year;
    logic [5:0]        nxt_sec, nxt_min;
    logic [4:0]        nxt_hour, nxt_day;
    logic [3:0]        nxt_mon;
    logic [YEAR_W-1:0] nxt_year;

    assign sec_wrap  = (sec_q == 6'd59);
    assign min_wrap  = (min_q == 6'd59);
    assign hour_wrap = (hour_q == 5'd23);
    assign day_wrap  = (day_q >= month_len(mon_q, year_q));
    assign mon_wrap  = (mon_q == 4'd12);

    assign c_min  = sec_wrap;
    assign c_hour = c_min && min_wrap;
    assign c_day  = c_hour && hour_wrap;
    assign c_mon  = c_day && day_wrap;
    assign c_year = c_mon && mon_wrap;

    assign nxt_sec  = sec_wrap ? 6'd0 : sec_q + 6'd1;
    assign nxt_min  = c_min  ? (min_wrap  ? 6'd0 : min_q + 6'd1)  : min_q;
    assign nxt_hour = c_hour ? (hour_wrap ? 5'd0 : hour_q + 5'd1) : hour_q;
    assign nxt_day  = c_day  ? (day_wrap  ? 5'd1 : day_q + 5'd1)  : day_q;
    assign nxt_mon  = c_mon  ? (mon_wrap  ? 4'd1 : mon_q + 4'd1)  : mon_q;
    assign nxt_year = c_year ? ((year_q >= YEAR_W'(99)) ? '0 : year_q + YEAR_W'(1)) : year_q;

    // Month length for the validity check comes from the values being loaded, not the current date.
    logic load_ok;
    assign load_ok = (bus.load_sec <= 6'd59) && (bus.load_min <= 6'd59) &&
                     (bus.load_hour <= 5'd23) &&
                     (bus.load_month >= 4'd1) && (bus.load_month <= 4'd12) &&
                     (bus.load_day >= 5'd1) &&
                     (bus.load_day <= month_len(bus.load_month, bus.load_year)) &&
                     (bus.load_year <= YEAR_W'(99));

    // State update: reset, then load (valid or rejected), then prescaler/tick cascade.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q     <= '0;
            sec_q       <= '0;
            min_q       <= '0;
            hour_q      <= '0;
            day_q       <= 5'd1;
            mon_q       <= 4'd1;
            year_q      <= '0;
            sec_tick_q  <= 1'b0;
            min_pulse_q <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            sec_tick_q  <= 1'b0;
            min_pulse_q <= 1'b0;
            alarm_q     <= 1'b0;
            load_err_q  <= 1'b0;
            if (bus.load) begin
                if (load_ok) begin
                    presc_q <= '0;
                    sec_q   <= bus.load_sec;
                    min_q   <= bus.load_min;
                    hour_q  <= bus.load_hour;
                    day_q   <= bus.load_day;
                    mon_q   <= bus.load_month;
                    year_q  <= bus.load_year;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.en) begin
                presc_q <= tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    sec_q       <= nxt_sec;
                    min_q       <= nxt_min;
                    hour_q      <= nxt_hour;
                    day_q       <= nxt_day;
                    mon_q       <= nxt_mon;
                    year_q      <= nxt_year;
                    sec_tick_q  <= 1'b1;
                    min_pulse_q <= sec_wrap;
                    alarm_q     <= sec_wrap && bus.alarm_en &&
                                   (nxt_hour == bus.alarm_hour) && (nxt_min == bus.alarm_min);
                end
            end
        end
    end

    assign bus.seconds   = sec_q;
    assign bus.minutes   = min_q;
    assign bus.hours     = hour_q;
    assign bus.days      = day_q;
    assign bus.months    = mon_q;
    assign bus.years     = year_q;
    assign bus.sec_tick  = sec_tick_q;
    assign bus.min_pulse = min_pulse_q;
    assign bus.alarm     = alarm_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_rtc_calendar.sv
// Purpose: directed checks of rtc_calendar, Gregorian (CLK_HZ=4) and 30-day-month instances side by side.
// Latency: inputs driven on falling clk edges, outputs sampled on the following falling edge.
// Backpressure: none; a watchdog bounds the run.
module tb_rtc_calendar;
    localparam int YW = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          en, load, alarm_en;
    logic [5:0]    l_sec, l_min, a_min;
    logic [4:0]    l_hour, l_day, a_hour;
    logic [3:0]    l_mon;
    logic [YW-1:0] l_year;

    rtc_calendar_if #(.YEAR_W(YW)) bus1 ();
    rtc_calendar_if #(.YEAR_W(YW)) bus0 ();

    assign bus1.en = en;          assign bus0.en = en;
    assign bus1.load = load;      assign bus0.load = load;
    assign bus1.load_sec = l_sec; assign bus0.load_sec = l_sec;
    assign bus1.load_min = l_min; assign bus0.load_min = l_min;
    assign bus1.load_hour = l_hour;  assign bus0.load_hour = l_hour;
    assign bus1.load_day = l_day;    assign bus0.load_day = l_day;
    assign bus1.load_month = l_mon;  assign bus0.load_month = l_mon;
    assign bus1.load_year = l_year;  assign bus0.load_year = l_year;
    assign bus1.alarm_en = alarm_en; assign bus0.alarm_en = alarm_en;
    assign bus1.alarm_hour = a_hour; assign bus0.alarm_hour = a_hour;
    assign bus1.alarm_min = a_min;   assign bus0.alarm_min = a_min;

    rtc_calendar #(.CLK_HZ(4), .MONTH_MODE(1), .YEAR_W(YW)) dut  (.clk(clk), .reset(reset), .bus(bus1));
    rtc_calendar #(.CLK_HZ(4), .MONTH_MODE(0), .YEAR_W(YW)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".hours"},   int'(bus1.hours),   h);
        chk({tag, ".minutes"}, int'(bus1.minutes), m);
        chk({tag, ".seconds"}, int'(bus1.seconds), s);
    endtask

    task automatic chk_date(input string tag, input int d, input int mo, input int y);
        chk({tag, ".days"},   int'(bus1.days),   d);
        chk({tag, ".months"}, int'(bus1.months), mo);
        chk({tag, ".years"},  int'(bus1.years),  y);
    endtask

    // Called on a falling edge; load is sampled by the next rising edge, returns on the falling edge after it.
    task automatic do_load(input int h, input int m, input int s, input int d, input int mo, input int y);
        l_hour = 5'(h); l_min = 6'(m); l_sec = 6'(s);
        l_day = 5'(d);  l_mon = 4'(mo); l_year = YW'(y);
        load = 1'b1;
        @(posedge clk); @(negedge clk);
        load = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        reset = 1'b1; en = 1'b1; load = 1'b0; alarm_en = 1'b0;
        a_hour = '0; a_min = '0;
        l_sec = '0; l_min = '0; l_hour = '0; l_day = '0; l_mon = '0; l_year = '0;

        // Reset values, before and after clock edges with en=1
        #1;
        chk_time("rst0", 0, 0, 0);
        chk_date("rst0", 1, 1, 0);
        chk("rst0.sec_tick", int'(bus1.sec_tick), 0);
        chk("rst0.load_err", int'(bus1.load_err), 0);
        step(2);
        chk_time("rst1", 0, 0, 0);

        // Free run from reset: sec_tick every 4 cycles, 1 minute after 240 cycles
        reset = 1'b0;
        ticks = 0;
        for (int k = 1; k <= 240; k++) begin
            step(1);
            if (bus1.sec_tick) ticks++;
            if (k <= 8) chk($sformatf("run.sec_tick@%0d", k), int'(bus1.sec_tick), (k % 4 == 0) ? 1 : 0);
            if (k == 236) begin
                chk_time("run236", 0, 0, 59);
                chk("run236.min_pulse", int'(bus1.min_pulse), 0);
            end
        end
        chk("run.tick_count", ticks, 60);
        chk_time("run240", 0, 1, 0);
        chk("run240.min_pulse", int'(bus1.min_pulse), 1);

        // Full cascade rollover at end of century
        do_load(23, 59, 59, 31, 12, 99);
        chk_time("ld_eoy", 23, 59, 59);
        chk_date("ld_eoy", 31, 12, 99);
        chk("ld_eoy.sec_tick", int'(bus1.sec_tick), 0);
        chk("ld_eoy.min_pulse", int'(bus1.min_pulse), 0);
        step(4);
        chk_time("eoy", 0, 0, 0);
        chk_date("eoy", 1, 1, 0);
        chk("eoy.sec_tick", int'(bus1.sec_tick), 1);
        chk("eoy.min_pulse", int'(bus1.min_pulse), 1);
        chk("eoy.alarm_off", int'(bus1.alarm), 0);

        // February in leap and common years
        do_load(23, 59, 59, 28, 2, 4);
        step(4);
        chk_time("leap", 0, 0, 0);
        chk_date("leap", 29, 2, 4);
        do_load(23, 59, 59, 28, 2, 5);
        step(4);
        chk_date("common", 1, 3, 5);

        // Load validity on both month modes
        do_load(1, 2, 3, 15, 6, 10);
        chk("valid.load_err", int'(bus1.load_err), 0);
        do_load(5, 6, 7, 31, 4, 20);
        chk("apr31.load_err", int'(bus1.load_err), 1);
        chk_time("apr31", 1, 2, 3);
        chk_date("apr31", 15, 6, 10);
        do_load(1, 2, 3, 31, 1, 10);
        chk("jan31.load_err", int'(bus1.load_err), 0);
        chk("jan31.days", int'(bus1.days), 31);
        chk("m0_jan31.load_err", int'(bus0.load_err), 1);
        chk("m0_jan31.days", int'(bus0.days), 15);
        do_load(1, 2, 3, 30, 2, 5);
        chk("feb30.load_err", int'(bus1.load_err), 1);
        chk("feb30.days", int'(bus1.days), 31);
        chk("m0_feb30.load_err", int'(bus0.load_err), 0);
        chk("m0_feb30.days", int'(bus0.days), 30);
        chk("m0_feb30.months", int'(bus0.months), 2);
        step(1);
        chk("load_err_clear", int'(bus1.load_err), 0);

        // Alarm fires on the minute wrap into 07:30, not on a direct load of 07:30:00
        alarm_en = 1'b1; a_hour = 5'd7; a_min = 6'd30;
        do_load(7, 29, 59, 1, 1, 0);
        chk("al_ld.alarm", int'(bus1.alarm), 0);
        step(4);
        chk_time("al", 7, 30, 0);
        chk("al.alarm", int'(bus1.alarm), 1);
        step(1);
        chk("al_next.alarm", int'(bus1.alarm), 0);
        do_load(7, 30, 0, 1, 1, 0);
        chk("al_direct.alarm", int'(bus1.alarm), 0);
        alarm_en = 1'b0;

        // Load on a tick cycle: load wins, tick discarded, prescaler restarts
        do_load(10, 20, 30, 5, 5, 50);
        step(3);
        do_load(11, 22, 33, 6, 6, 60);
        chk_time("ld_tick", 11, 22, 33);
        chk("ld_tick.sec_tick", int'(bus1.sec_tick), 0);
        step(3);
        chk("ld_tick3.seconds", int'(bus1.seconds), 33);
        step(1);
        chk("ld_tick4.sec_tick", int'(bus1.sec_tick), 1);
        chk("ld_tick4.seconds", int'(bus1.seconds), 34);

        // en low for 10 cycles freezes counters and prescaler
        step(2);
        en = 1'b0;
        ticks = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (bus1.sec_tick) ticks++;
        end
        chk("frz.ticks", ticks, 0);
        chk("frz.seconds", int'(bus1.seconds), 34);
        en = 1'b1;
        step(1);
        chk("frz1.sec_tick", int'(bus1.sec_tick), 0);
        step(1);
        chk("frz2.sec_tick", int'(bus1.sec_tick), 1);
        chk("frz2.seconds", int'(bus1.seconds), 35);

        // Asynchronous reset mid-count, also overriding a pending load
        l_hour = 5'd3; l_min = 6'd4; l_sec = 6'd5; l_day = 5'd6; l_mon = 4'd7; l_year = YW'(8);
        load = 1'b1;
        reset = 1'b1;
        #1;
        chk_time("arst", 0, 0, 0);
        chk_date("arst", 1, 1, 0);
        step(1);
        chk_time("arst_ld", 0, 0, 0);
        chk("arst_ld.days", int'(bus1.days), 1);
        load = 1'b0;
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
